// File: rtl/port_rd_frontend.sv
// Per-port read frontend: buffers whole packets from the SRAM read path and replays them as sop/vld.../eop.
// Latency: a complete buffered packet shows rd_sop 2 cycles after ready is seen in IDLE; outputs are registered.
// Backpressure: xfer_ready drops AF_GAP entries before full; words arriving when full are dropped (sticky overflow).
// Optional PORT_RD_STATS_EN adds pkt_out_cnt / drop_cnt.
module port_rd_frontend #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 512,
    parameter int AF_GAP     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  xfer_data_vld,
    input  logic [DATA_WIDTH-1:0] xfer_data,
    input  logic                  xfer_end_of_packet,
    output logic                  xfer_ready,
    output logic                  overflow,
    input  logic                  ready,
    output logic                  rd_sop,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_eop
`ifdef PORT_RD_STATS_EN
    ,
    output logic [15:0]           pkt_out_cnt,
    output logic [15:0]           drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_LIMIT = (AW+1)'(DEPTH - AF_GAP);

    typedef struct packed {
        logic                  eop;
        logic [DATA_WIDTH-1:0] dat;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        SOP,
        DATA,
        EOP
    } state_t;

    entry_t mem [DEPTH];

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic [AW:0]           pkt_cnt_q, pkt_cnt_d;
    state_t                state_q, state_d;
    logic                  xfer_ready_q, xfer_ready_d;
    logic                  overflow_q, overflow_d;
    logic                  rd_sop_q, rd_sop_d;
    logic                  rd_vld_q, rd_vld_d;
    logic                  rd_eop_q, rd_eop_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic   full;
    logic   push;
    logic   drop;
    logic   pop;
    entry_t head;
    entry_t wr_entry;

    // Same index with differing wrap bits means the writer has lapped the reader.
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push     = xfer_data_vld && !full;
    assign drop     = xfer_data_vld && full;
    assign pop      = (state_q == DATA);
    assign head     = mem[rd_ptr_q[AW-1:0]];
    assign wr_entry = '{eop: xfer_end_of_packet, dat: xfer_data};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
        count_d   = count_q;
        pkt_cnt_d = pkt_cnt_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        case ({push && xfer_end_of_packet, pop && head.eop})
            2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
            2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
        // Free entries > AF_GAP  <=>  count < DEPTH - AF_GAP
        xfer_ready_d = (count_d < AF_LIMIT);
        overflow_d   = overflow_q || drop;
    end

    // Each state's output is registered, so it appears on the pins the cycle after
    // the state; this keeps sop->vld and last vld->eop back to back.
    always_comb begin
        state_d   = state_q;
        rd_sop_d  = 1'b0;
        rd_vld_d  = 1'b0;
        rd_eop_d  = 1'b0;
        rd_data_d = '0;
        case (state_q)
            IDLE: begin
                if (ready && (pkt_cnt_q != '0)) begin
                    state_d = SOP;
                end
            end
            SOP: begin
                rd_sop_d = 1'b1;
                state_d  = DATA;
            end
            DATA: begin
                rd_vld_d  = 1'b1;
                rd_data_d = head.dat;
                if (head.eop) begin
                    state_d = EOP;
                end
            end
            EOP: begin
                rd_eop_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pkt_cnt_q    <= '0;
            state_q      <= IDLE;
            xfer_ready_q <= 1'b1;
            overflow_q   <= 1'b0;
            rd_sop_q     <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_eop_q     <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pkt_cnt_q    <= pkt_cnt_d;
            state_q      <= state_d;
            xfer_ready_q <= xfer_ready_d;
            overflow_q   <= overflow_d;
            rd_sop_q     <= rd_sop_d;
            rd_vld_q     <= rd_vld_d;
            rd_eop_q     <= rd_eop_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign xfer_ready = xfer_ready_q;
    assign overflow   = overflow_q;
    assign rd_sop     = rd_sop_q;
    assign rd_vld     = rd_vld_q;
    assign rd_data    = rd_data_q;
    assign rd_eop     = rd_eop_q;

`ifdef PORT_RD_STATS_EN
    logic [15:0] pkt_out_cnt_q, pkt_out_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        pkt_out_cnt_d = pkt_out_cnt_q + {15'd0, (state_q == EOP)};
        drop_cnt_d    = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_out_cnt_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pkt_out_cnt_q <= pkt_out_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign pkt_out_cnt = pkt_out_cnt_q;
    assign drop_cnt    = drop_cnt_q;
`endif

endmodule
